mem_port_arbiter: RTL and testbench

- Shares one single-ported unified memory between the Fetch-stage instruction port and the Memory-stage data port of the pipelined RV32I core.
- The memory has a variable-latency req/ack handshake.
- The block sequences accesses and holds completed results until the whole pipeline can advance.
- It produces memStall, which the hazard logic ORs into stallF/stallD and the E/M/W enables.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_perf.sv | 22 ++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DATA_WAIT = 2'd1,
    INST_WAIT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_perf.sv
// Performance counters for the memory port arbiter: stall cycles and
// IDLE-cycle fetch/data conflicts, both free-running and wrapping.
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        conflict,
  output logic [31:0] stall_cycles,
  output logic [31:0] conflicts
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'd0;
      conflicts    <= 32'd0;
    end else begin
      if (stall)    stall_cycles <= stall_cycles + 32'd1;
      if (conflict) conflicts    <= conflicts + 32'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between the fetch and M-stage data ports,
// holding results until the pipeline advances. Optional counters: MEM_ARB_PERF_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W,
  parameter int unsigned DATA_WIDTH = DATA_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instReqF,
  input  logic [ADDR_WIDTH-1:0]   instAddrF,
  output logic [DATA_WIDTH-1:0]   instRdataF,
  output logic                    instValidF,
  input  logic                    dataReqM,
  input  logic                    dataWeM,
  input  logic [ADDR_WIDTH-1:0]   dataAddrM,
  input  logic [DATA_WIDTH-1:0]   dataWdataM,
  input  logic [DATA_WIDTH/8-1:0] dataBeM,
  output logic [DATA_WIDTH-1:0]   dataRdataM,
  output logic                    dataDoneM,
  input  logic                    redirectE,
  output logic                    memStall,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perfStallCycles,
  output logic [31:0]             perfConflicts
`endif
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  arb_state_t            state_q, state_d;
  logic                  inst_hold_q, inst_hold_d;
  logic                  data_hold_q, data_hold_d;
  logic                  drop_q, drop_d;
  logic                  req_d, we_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [BE_WIDTH-1:0]   be_d;
  logic [DATA_WIDTH-1:0] irdata_d, drdata_d;
  logic                  advance;

  // The whole pipeline may move only when every active port has its result held.
  assign advance    = (!dataReqM || data_hold_q) && (!instReqF || inst_hold_q);
  assign memStall   = !advance;
  assign instValidF = inst_hold_q;
  assign dataDoneM  = data_hold_q;

  always_comb begin
    state_d     = state_q;
    inst_hold_d = inst_hold_q;
    data_hold_d = data_hold_q;
    drop_d      = drop_q;
    req_d       = mem_req;
    we_d        = mem_we;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    be_d        = mem_be;
    irdata_d    = instRdataF;
    drdata_d    = dataRdataM;

    if (advance) begin
      inst_hold_d = 1'b0;
      data_hold_d = 1'b0;
    end
    if (redirectE) inst_hold_d = 1'b0;

    case (state_q)
      // Data wins ties: the M-stage instruction is older than the fetch.
      IDLE: begin
        if (dataReqM && !data_hold_q) begin
          req_d   = 1'b1;
          we_d    = dataWeM;
          addr_d  = dataAddrM;
          wdata_d = dataWdataM;
          be_d    = dataBeM;
          state_d = DATA_WAIT;
        end else if (instReqF && !inst_hold_q && !redirectE) begin
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = instAddrF;
          be_d    = '1;
          state_d = INST_WAIT;
        end
      end
      DATA_WAIT: begin
        if (mem_ack) begin
          req_d       = 1'b0;
          if (!mem_we) drdata_d = mem_rdata;
          data_hold_d = 1'b1;
          state_d     = IDLE;
        end
      end
      // A redirect cannot abort the access; the stale word is dropped on ack.
      INST_WAIT: begin
        if (redirectE) drop_d = 1'b1;
        if (mem_ack) begin
          req_d = 1'b0;
          if (!drop_q && !redirectE) begin
            irdata_d    = mem_rdata;
            inst_hold_d = 1'b1;
          end else begin
            drop_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      inst_hold_q <= 1'b0;
      data_hold_q <= 1'b0;
      drop_q      <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_be      <= '0;
      instRdataF  <= '0;
      dataRdataM  <= '0;
    end else begin
      state_q     <= state_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
      drop_q      <= drop_d;
      mem_req     <= req_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      mem_be      <= be_d;
      instRdataF  <= irdata_d;
      dataRdataM  <= drdata_d;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (state_q == IDLE) && dataReqM && !data_hold_q &&
                    instReqF && !inst_hold_q;

  mem_arb_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall        (memStall),
    .conflict     (conflict),
    .stall_cycles (perfStallCycles),
    .conflicts    (perfConflicts)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a variable-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ireq, dreq, dwe, redir;
  logic [31:0] iaddr, daddr, dwdata;
  logic [3:0]  dbe;
  logic [31:0] instRdataF, dataRdataM;
  logic        instValidF, dataDoneM, memStall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perfStallCycles, perfConflicts;
`endif

  int errors = 0;
  int checks = 0;
  int reqcycles = 0;
  int violations = 0;
  int r0;

  logic [7:0]  lat;
  logic [7:0]  cnt;
  logic        spurious;
  logic        prev_req;
  logic [68:0] prev_cmd;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .instReqF   (ireq),
    .instAddrF  (iaddr),
    .instRdataF (instRdataF),
    .instValidF (instValidF),
    .dataReqM   (dreq),
    .dataWeM    (dwe),
    .dataAddrM  (daddr),
    .dataWdataM (dwdata),
    .dataBeM    (dbe),
    .dataRdataM (dataRdataM),
    .dataDoneM  (dataDoneM),
    .redirectE  (redir),
    .memStall   (memStall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .perfStallCycles (perfStallCycles),
    .perfConflicts   (perfConflicts)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_2000: return 32'hDEAD_BEEF;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Memory model: ack is seen during the lat-th cycle of a request.
  assign mem_ack   = (mem_req && (cnt == lat - 8'd1)) || spurious;
  assign mem_rdata = mem_word(mem_addr);

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) cnt <= 8'd0;
    else                            cnt <= cnt + 8'd1;
  end

  always @(posedge clk) begin
    if (mem_req) reqcycles++;
    if (rst) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req && prev_req && ({mem_we, mem_addr, mem_wdata, mem_be} != prev_cmd))
        violations++;
      prev_req = mem_req;
      prev_cmd = {mem_we, mem_addr, mem_wdata, mem_be};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; redir = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dwdata = 32'h0; dbe = 4'h0;
    lat = 8'd1; spurious = 1'b0;
    tick(); tick();
    chk("rst_mem_req",   32'(mem_req),    32'd0);
    chk("rst_mem_we",    32'(mem_we),     32'd0);
    chk("rst_mem_addr",  mem_addr,        32'h0);
    chk("rst_mem_wdata", mem_wdata,       32'h0);
    chk("rst_mem_be",    32'(mem_be),     32'h0);
    chk("rst_ivalid",    32'(instValidF), 32'd0);
    chk("rst_ddone",     32'(dataDoneM),  32'd0);
    chk("rst_irdata",    instRdataF,      32'h0);
    chk("rst_drdata",    dataRdataM,      32'h0);
    chk("rst_stall",     32'(memStall),   32'd0);
    rst = 1'b0;
    tick();

    // Fetch only, latency 3
    lat = 8'd3; ireq = 1'b1; iaddr = 32'h100;
    #1 chk("f_stall_pre", 32'(memStall), 32'd1);
    r0 = reqcycles;
    tick();
    chk("f_req",  32'(mem_req), 32'd1);
    chk("f_addr", mem_addr,     32'h100);
    chk("f_we",   32'(mem_we),  32'd0);
    chk("f_be",   32'(mem_be),  32'hF);
    tick(); tick();
    chk("f_req_c3",  32'(mem_req),    32'd1);
    chk("f_ival_c3", 32'(instValidF), 32'd0);
    tick();
    chk("f_req_done", 32'(mem_req),    32'd0);
    chk("f_ival",     32'(instValidF), 32'd1);
    chk("f_irdata",   instRdataF,      32'h0050_0093);
    chk("f_stall",    32'(memStall),   32'd0);
    chk("f_reqcyc",   32'(reqcycles - r0), 32'd3);
    ireq = 1'b0;
    tick();
    chk("f_ival_clr", 32'(instValidF), 32'd0);

    // Load plus fetch, latency 1: data first
    lat = 8'd1; dreq = 1'b1; dwe = 1'b0; daddr = 32'h2000; ireq = 1'b1; iaddr = 32'h104;
    #1 chk("lf_stall_pre", 32'(memStall), 32'd1);
    tick();
    chk("lf_d_req",  32'(mem_req), 32'd1);
    chk("lf_d_addr", mem_addr,     32'h2000);
    chk("lf_d_we",   32'(mem_we),  32'd0);
    tick();
    chk("lf_idle_req", 32'(mem_req),   32'd0);
    chk("lf_ddone",    32'(dataDoneM), 32'd1);
    chk("lf_drdata",   dataRdataM,     32'hDEAD_BEEF);
    chk("lf_stall_1",  32'(memStall),  32'd1);
    tick();
    chk("lf_i_req",   32'(mem_req),  32'd1);
    chk("lf_i_addr",  mem_addr,      32'h104);
    chk("lf_stall_2", 32'(memStall), 32'd1);
    chk("lf_drdata2", dataRdataM,    32'hDEAD_BEEF);
    tick();
    chk("lf_ival",    32'(instValidF), 32'd1);
    chk("lf_irdata",  instRdataF,      32'hA5A5_0104);
    chk("lf_ddone2",  32'(dataDoneM),  32'd1);
    chk("lf_drdata3", dataRdataM,      32'hDEAD_BEEF);
    chk("lf_stall_3", 32'(memStall),   32'd0);
    dreq = 1'b0; ireq = 1'b0;
    tick();
    chk("lf_ddone_clr", 32'(dataDoneM),  32'd0);
    chk("lf_ival_clr",  32'(instValidF), 32'd0);

    // Store, latency 2
    lat = 8'd2; dreq = 1'b1; dwe = 1'b1; daddr = 32'h2004; dwdata = 32'h1234_5678; dbe = 4'b0011;
    tick();
    chk("st_req",   32'(mem_req), 32'd1);
    chk("st_we",    32'(mem_we),  32'd1);
    chk("st_be",    32'(mem_be),  32'h3);
    chk("st_wdata", mem_wdata,    32'h1234_5678);
    chk("st_addr",  mem_addr,     32'h2004);
    tick();
    chk("st_req_c2", 32'(mem_req), 32'd1);
    chk("st_we_c2",  32'(mem_we),  32'd1);
    chk("st_be_c2",  32'(mem_be),  32'h3);
    tick();
    chk("st_req_done", 32'(mem_req),   32'd0);
    chk("st_ddone",    32'(dataDoneM), 32'd1);
    chk("st_drdata",   dataRdataM,     32'hDEAD_BEEF);
    chk("st_stall",    32'(memStall),  32'd0);
    dreq = 1'b0; dwe = 1'b0; dbe = 4'h0;
    tick();

    // Redirect mid INST_WAIT, latency 3
    lat = 8'd3; ireq = 1'b1; iaddr = 32'h104;
    tick();
    chk("rd_addr", mem_addr, 32'h104);
    redir = 1'b1; iaddr = 32'h200;
    tick();
    redir = 1'b0;
    chk("rd_not_abort", 32'(mem_req), 32'd1);
    tick(); tick();
    chk("rd_req_done", 32'(mem_req),    32'd0);
    chk("rd_ival",     32'(instValidF), 32'd0);
    chk("rd_stall",    32'(memStall),   32'd1);
    tick();
    chk("rd_refetch_req",  32'(mem_req), 32'd1);
    chk("rd_refetch_addr", mem_addr,     32'h200);
    tick(); tick(); tick();
    chk("rd_ival2",  32'(instValidF), 32'd1);
    chk("rd_irdata", instRdataF,      32'hA5A5_0200);
    ireq = 1'b0;
    tick();

    // Redirect coincident with ack, latency 2
    lat = 8'd2; ireq = 1'b1; iaddr = 32'h300;
    tick();
    chk("rc_addr", mem_addr, 32'h300);
    tick();
    redir = 1'b1; iaddr = 32'h304;
    tick();
    redir = 1'b0;
    chk("rc_req_done", 32'(mem_req),    32'd0);
    chk("rc_ival",     32'(instValidF), 32'd0);
    chk("rc_irdata",   instRdataF,      32'hA5A5_0200);
    tick();
    chk("rc_refetch_req",  32'(mem_req), 32'd1);
    chk("rc_refetch_addr", mem_addr,     32'h304);
    tick(); tick();
    chk("rc_ival2",  32'(instValidF), 32'd1);
    chk("rc_irdata2", instRdataF,     32'hA5A5_0304);
    ireq = 1'b0;
    tick();

    // Ack in IDLE is ignored
    spurious = 1'b1;
    tick();
    spurious = 1'b0;
    chk("sp_req",    32'(mem_req),    32'd0);
    chk("sp_ival",   32'(instValidF), 32'd0);
    chk("sp_ddone",  32'(dataDoneM),  32'd0);
    chk("sp_drdata", dataRdataM,      32'hDEAD_BEEF);
    lat = 8'd1; ireq = 1'b1; iaddr = 32'h100;
    tick();
    chk("sp_next_req", 32'(mem_req), 32'd1);
    tick();
    chk("sp_next_ival", 32'(instValidF), 32'd1);
    ireq = 1'b0;
    tick();

    // Reset during DATA_WAIT
    lat = 8'd5; dreq = 1'b1; daddr = 32'h2008;
    tick();
    chk("rw_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    chk("rw_mem_req",   32'(mem_req),    32'd0);
    chk("rw_mem_we",    32'(mem_we),     32'd0);
    chk("rw_mem_addr",  mem_addr,        32'h0);
    chk("rw_mem_wdata", mem_wdata,       32'h0);
    chk("rw_mem_be",    32'(mem_be),     32'h0);
    chk("rw_drdata",    dataRdataM,      32'h0);
    chk("rw_irdata",    instRdataF,      32'h0);
    chk("rw_ddone",     32'(dataDoneM),  32'd0);
    chk("rw_ival",      32'(instValidF), 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("rw_perf_stall",    perfStallCycles, 32'd0);
    chk("rw_perf_conflict", perfConflicts,   32'd0);
`endif
    dreq = 1'b0;
    #1 chk("rw_stall", 32'(memStall), 32'd0);
    rst = 1'b0; lat = 8'd1; ireq = 1'b1; iaddr = 32'h100;
    tick();
    chk("rw_idle_req",  32'(mem_req), 32'd1);
    chk("rw_idle_addr", mem_addr,     32'h100);
    tick();
    chk("rw_ival",   32'(instValidF), 32'd1);
    chk("rw_irdata", instRdataF,      32'h0050_0093);
    ireq = 1'b0;
    tick();

    chk("req_stability", 32'(violations), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
